alu_flopr: RTL and testbench

- Execution-and-state leaf block of the single-cycle MIPS datapath.
- It bundles two independent functions:
  - a combinational 32-bit ALU, driven by the 3-bit alucontrol code from the ALU decoder;
  - a resettable D register of parameterised width, used as the program-counter register.
- The datapath uses the ALU result for the data address, writeback and zero-flag branch decisions.
- It uses the register, with WIDTH=32, to hold the PC.

---
 rtl/mips_pkg.sv | 15 +
 rtl/alu.sv | 35 +++
 rtl/flopr.sv | 20 ++
 rtl/alu_flopr.sv | 38 +++
 tb/tb_alu_flopr.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: ALU operation codes and the data width.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_RSV  = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational ALU selected by the 3-bit alucontrol code from the ALU decoder.
module alu
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = mips_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      alucontrol,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic lt;

    // Signed compare rather than the sign of a - b, so overflow cannot flip it.
    assign lt = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
            ALU_ANDN: result = a & ~b;
            ALU_ORN:  result = a | ~b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/flopr.sv
// Resettable D register; holds the program counter in the datapath.
module flopr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Active-low asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_flopr.sv
// Wrapper bundling the datapath ALU and the PC register.
module alu_flopr
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned XLEN  = mips_pkg::XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [2:0]       alucontrol,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    flopr #(
        .WIDTH(WIDTH)
    ) u_flopr (
        .clk  (clk),
        .reset(reset),
        .d    (d),
        .q    (q)
    );

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .a         (a),
        .b         (b),
        .alucontrol(alucontrol),
        .result    (result),
        .zero      (zero)
    );

endmodule

// File: tb/tb_alu_flopr.sv
// Self-checking bench for alu_flopr: directed register/ALU cases plus randomized model checks.
module tb_alu_flopr;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alucontrol;
    logic [31:0] result;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_flopr #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .q         (q),
        .a         (a),
        .b         (b),
        .alucontrol(alucontrol),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic        z;
    } vec_t;

    // Reference ALU from plain arithmetic on wide unsigned and signed integers.
    function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] x, logic [31:0] y);
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        logic [63:0]     s;
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: begin s = ux + uy; return s[31:0]; end
            3'd6: begin s = ux + 64'h1_0000_0000 - uy; return s[31:0]; end
            3'd7: return (sx < sy) ? 32'd1 : 32'd0;
            3'd4: return x & ~y;
            3'd5: return x | ~y;
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        d = 32'hDEADBEEF;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 32'h0) begin
            n_err++; $display("FAIL reset_init q=%h expected %h", q, 32'h0);
        end
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL reset_load q=%h expected %h", q, 32'hDEADBEEF);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 32'h0) begin
            n_err++; $display("FAIL reset_async q=%h expected %h", q, 32'h0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 32'h0) begin
            n_err++; $display("FAIL reset_hold q=%h expected %h", q, 32'h0);
        end
        @(negedge clk) reset = 1'b1;
        #1;
        n_cmp++;
        if (q !== 32'h0) begin
            n_err++; $display("FAIL reset_release q=%h expected %h", q, 32'h0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL reset_first_edge q=%h expected %h", q, 32'hDEADBEEF);
        end
    endtask

    task automatic test_pipeline();
        logic [31:0] seq [3] = '{32'd0, 32'd4, 32'd8};
        logic [31:0] prev = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) d = seq[i];
            #1;
            n_cmp++;
            if (q !== prev) begin
                n_err++; $display("FAIL pipe_before[%0d] q=%h expected %h", i, q, prev);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (q !== seq[i]) begin
                n_err++; $display("FAIL pipe_after[%0d] q=%h expected %h", i, q, seq[i]);
            end
            prev = seq[i];
        end
        @(negedge clk) begin d = 32'd4; reset = 1'b0; end
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 32'h0) begin
            n_err++; $display("FAIL pipe_reset_edge q=%h expected %h", q, 32'h0);
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_register_random();
        logic [31:0] exp_q = 32'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            d = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b0;
                exp_q = 32'h0;
                #1;
                n_cmp++;
                if (q !== exp_q) begin
                    n_err++; $display("FAIL rand_async[%0d] q=%h expected %h", i, q, exp_q);
                end
            end else begin
                reset = 1'b1;
                exp_q = d;
            end
            @(posedge clk); #1;
            n_cmp++;
            if (q !== exp_q) begin
                n_err++; $display("FAIL rand_reg[%0d] q=%h expected %h", i, q, exp_q);
            end
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_alu_directed();
        vec_t v [16] = '{
            '{3'b010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1},
            '{3'b110, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0},
            '{3'b110, 32'h1234,     32'h1234,     32'h0,        1'b1},
            '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0},
            '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0},
            '{3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0},
            '{3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0FFF0FF, 1'b0},
            '{3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        1'b1},
            '{3'b111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0},
            '{3'b111, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1},
            '{3'b111, 32'h80000000, 32'h1,        32'h1,        1'b0},
            '{3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h0,        1'b1},
            '{3'b111, 32'h00C0FFEE, 32'h00C0FFEE, 32'h0,        1'b1},
            '{3'b010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0},
            '{3'b110, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0},
            '{3'b000, 32'hAAAAAAAA, 32'h55555555, 32'h0,        1'b1}
        };
        for (int i = 0; i < 16; i++) begin
            alucontrol = v[i].op;
            a = v[i].x;
            b = v[i].y;
            #1;
            n_cmp++;
            if (result !== v[i].r) begin
                n_err++;
                $display("FAIL alu_dir_result[%0d] op=%b result=%h expected %h",
                         i, v[i].op, result, v[i].r);
            end
            n_cmp++;
            if (zero !== v[i].z) begin
                n_err++;
                $display("FAIL alu_dir_zero[%0d] op=%b zero=%b expected %b",
                         i, v[i].op, zero, v[i].z);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] exp_r;
        for (int i = 0; i < 400; i++) begin
            alucontrol = 3'($urandom_range(0, 7));
            a = $urandom;
            // Bias some operands toward equality and sign-boundary values.
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = 32'h80000000;
                2: b = 32'h7FFFFFFF;
                default: b = $urandom;
            endcase
            exp_r = ref_alu(alucontrol, a, b);
            #1;
            n_cmp++;
            if (result !== exp_r || zero !== (exp_r == 32'h0)) begin
                n_err++;
                $display("FAIL alu_rand[%0d] op=%b a=%h b=%h result=%h zero=%b expected %h",
                         i, alucontrol, a, b, result, zero, exp_r);
            end
        end
    endtask

    initial begin
        d = '0;
        a = '0;
        b = '0;
        alucontrol = 3'b000;
        test_reset();
        test_pipeline();
        test_register_random();
        test_alu_directed();
        test_alu_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
